// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath.
package conv_pkg;

    localparam int PIXEL_W     = 8;
    localparam int IMAGE_MAX_W = 1920;
    localparam int WIN_K       = 3;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Window layout: [r][c], r=0 is the oldest row, c=0 is the oldest column.
    typedef pixel_t [WIN_K-1:0][WIN_K-1:0] win_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } win_state_t;

endpackage

// File: rtl/conv_win_col_sr.sv
// Two-deep enabled shift register holding the two previous columns of one window row.
module conv_win_col_sr
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               arst,
    input  logic               en,
    input  logic [PIXEL_W-1:0] din,
    output logic [PIXEL_W-1:0] q_old,
    output logic [PIXEL_W-1:0] q_new
);

    // Shift the newest column in on every accepted pixel; the older one moves down.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            q_old <= '0;
            q_new <= '0;
        end else if (en) begin
            q_old <= q_new;
            q_new <= din;
        end
    end

endmodule

// File: rtl/conv_win_asm.sv
// 3x3 window assembler: tracks frame/line position, forms windows from the
// live column plus two stored columns, and presents them through one
// registered valid/ready stage.
module conv_win_asm
    import conv_pkg::*;
#(
    parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic                             in_vld_i,
    output logic                             in_rdy_o,
    input  logic [PIXEL_W-1:0]               col0_i,
    input  logic [PIXEL_W-1:0]               col1_i,
    input  logic [PIXEL_W-1:0]               col2_i,
    input  logic                             sof_i,
    input  logic                             eol_i,
    input  logic                             eof_i,
    output logic                             win_vld_o,
    input  logic                             win_rdy_i,
    output logic [WIN_K*WIN_K*PIXEL_W-1:0]   win_o,
    output logic                             win_sof_o,
    output logic                             win_eol_o,
    output logic                             win_eof_o,
    output logic                             err_o
);

    localparam int XW = $clog2(IMAGE_MAX_W + 1);
    localparam logic [XW-1:0] XMAX = XW'(IMAGE_MAX_W);
    localparam logic [XW-1:0] XONE = XW'(1);
    localparam logic [XW-1:0] XTWO = XW'(2);

    win_state_t          state;
    logic [XW-1:0]       xcnt;
    logic [1:0]          ycnt;
    logic                first_pend;
    logic                acc;
    logic                emit;
    pixel_t              row_in [WIN_K];
    pixel_t              sr_old [WIN_K];
    pixel_t              sr_new [WIN_K];
    win_t                win_next;
    win_t                win_q;

    assign in_rdy_o = ~win_vld_o | win_rdy_i;
    assign acc      = in_vld_i & in_rdy_o;

    // A sof pixel is column 0 of a new frame, so it never closes an old-frame window.
    assign emit = acc && (state == RUN) && (xcnt >= XTWO) && !sof_i;

    // Row 0 of the window is the oldest image row (line buffer 1).
    assign row_in[0] = col2_i;
    assign row_in[1] = col1_i;
    assign row_in[2] = col0_i;

    for (genvar r = 0; r < WIN_K; r++) begin : g_row
        conv_win_col_sr u_sr (
            .clk   (clk),
            .arst  (arst),
            .en    (acc),
            .din   (row_in[r]),
            .q_old (sr_old[r]),
            .q_new (sr_new[r])
        );
    end

    // Window = two stored columns plus the live column, formed combinationally.
    always_comb begin
        win_next = '0;
        for (int r = 0; r < WIN_K; r++) begin
            win_next[r][0] = sr_old[r];
            win_next[r][1] = sr_new[r];
            win_next[r][2] = row_in[r];
        end
    end

    // Frame FSM with column/row counters and the sticky overflow flag.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            xcnt       <= '0;
            ycnt       <= '0;
            first_pend <= 1'b0;
            err_o      <= 1'b0;
        end else if (acc) begin
            if (sof_i) begin
                xcnt       <= eol_i ? '0 : XONE;
                ycnt       <= eol_i ? 2'd1 : 2'd0;
                first_pend <= 1'b1;
                err_o      <= 1'b0;
                state      <= eof_i ? IDLE : FILL;
            end else begin
                if (eol_i) begin
                    xcnt <= '0;
                end else if (xcnt != XMAX) begin
                    xcnt <= xcnt + XONE;
                end
                if (state != IDLE && xcnt == XMAX && !eol_i) begin
                    err_o <= 1'b1;
                end
                if (emit) begin
                    first_pend <= 1'b0;
                end
                if (state == FILL && eol_i) begin
                    ycnt <= ycnt + 2'd1;
                    if (ycnt == 2'd1) begin
                        state <= RUN;
                    end
                end
                if (eof_i) begin
                    state <= IDLE;
                end
            end
        end
    end

    // Output stage: load on emit, hold while downstream stalls, drop valid on handshake.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            win_q     <= '0;
            win_vld_o <= 1'b0;
            win_sof_o <= 1'b0;
            win_eol_o <= 1'b0;
            win_eof_o <= 1'b0;
        end else if (emit) begin
            win_q     <= win_next;
            win_vld_o <= 1'b1;
            win_sof_o <= first_pend;
            win_eol_o <= eol_i;
            win_eof_o <= eof_i;
        end else if (win_rdy_i) begin
            win_vld_o <= 1'b0;
        end
    end

    assign win_o = win_q;

endmodule

// File: tb/tb_conv_win_asm.sv
// Self-checking bench for conv_win_asm with a position-based reference model.
module tb_conv_win_asm;
    import conv_pkg::*;

    localparam int MAXW = 8;

    typedef struct packed {
        logic [71:0] win;
        logic        sof;
        logic        eol;
        logic        eof;
    } rec_t;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        in_vld_i = 1'b0;
    logic        in_rdy_o;
    logic [7:0]  col0_i = '0;
    logic [7:0]  col1_i = '0;
    logic [7:0]  col2_i = '0;
    logic        sof_i = 1'b0;
    logic        eol_i = 1'b0;
    logic        eof_i = 1'b0;
    logic        win_vld_o;
    logic        win_rdy_i = 1'b1;
    logic [71:0] win_o;
    logic        win_sof_o;
    logic        win_eol_o;
    logic        win_eof_o;
    logic        err_o;

    int n_vec = 0;
    int n_mis = 0;
    int rdy_mode = 0;
    bit rdy_tog = 1'b0;
    bit bubble_en = 1'b0;
    bit check_en = 1'b0;
    rec_t dut_log[$];

    // reference model state
    logic       m_vld, m_err, m_sof, m_eol, m_eof;
    win_t       m_win;
    bit         in_frame, first_pend;
    int         x_pos, y_pos;
    logic [7:0] h0 [3];
    logic [7:0] h1 [3];

    conv_win_asm #(.IMAGE_MAX_W(MAXW)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_vld_i  (in_vld_i),
        .in_rdy_o  (in_rdy_o),
        .col0_i    (col0_i),
        .col1_i    (col1_i),
        .col2_i    (col2_i),
        .sof_i     (sof_i),
        .eol_i     (eol_i),
        .eof_i     (eof_i),
        .win_vld_o (win_vld_o),
        .win_rdy_i (win_rdy_i),
        .win_o     (win_o),
        .win_sof_o (win_sof_o),
        .win_eol_o (win_eol_o),
        .win_eof_o (win_eof_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_vld = 1'b0; m_err = 1'b0; m_sof = 1'b0; m_eol = 1'b0; m_eof = 1'b0;
        m_win = '0;
        in_frame = 1'b0; first_pend = 1'b0;
        x_pos = 0; y_pos = 0;
        for (int r = 0; r < 3; r++) begin
            h0[r] = '0;
            h1[r] = '0;
        end
    endtask

    // One clock of the model: position bookkeeping from the frame markers.
    task automatic modelStep();
        logic acc, emit;
        logic [7:0] cur [3];
        acc  = in_vld_i && (!m_vld || win_rdy_i);
        emit = 1'b0;
        if (acc) begin
            cur[0] = col2_i;
            cur[1] = col1_i;
            cur[2] = col0_i;
            if (sof_i) begin
                in_frame   = !eof_i;
                m_err      = 1'b0;
                first_pend = 1'b1;
                if (eol_i) begin x_pos = 0; y_pos = 1; end
                else begin x_pos = 1; y_pos = 0; end
            end else if (in_frame) begin
                if (y_pos >= 2 && x_pos >= 2) emit = 1'b1;
                if (x_pos >= MAXW && !eol_i) m_err = 1'b1;
                if (eol_i) begin x_pos = 0; y_pos++; end
                else x_pos++;
                if (eof_i) in_frame = 1'b0;
            end
            if (emit) begin
                for (int r = 0; r < 3; r++) begin
                    m_win[r][0] = h0[r];
                    m_win[r][1] = h1[r];
                    m_win[r][2] = cur[r];
                end
                m_sof = first_pend;
                first_pend = 1'b0;
                m_eol = eol_i;
                m_eof = eof_i;
                m_vld = 1'b1;
            end else if (win_rdy_i) begin
                m_vld = 1'b0;
            end
            for (int r = 0; r < 3; r++) begin
                h0[r] = h1[r];
                h1[r] = cur[r];
            end
        end else if (win_rdy_i) begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge arst);
            if (arst) modelReset();
            else modelStep();
        end
    end

    // Compare the DUT with the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("in_rdy", 72'(in_rdy_o), 72'(!m_vld || win_rdy_i));
                checkOutput("win_vld", 72'(win_vld_o), 72'(m_vld));
                checkOutput("err", 72'(err_o), 72'(m_err));
                if (m_vld) begin
                    checkOutput("win", win_o, 72'(m_win));
                    checkOutput("win_sof", 72'(win_sof_o), 72'(m_sof));
                    checkOutput("win_eol", 72'(win_eol_o), 72'(m_eol));
                    checkOutput("win_eof", 72'(win_eof_o), 72'(m_eof));
                end
            end
        end
    end

    task automatic driveCycle(input logic vld, input logic s, input logic e, input logic f,
                              input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              output logic accepted);
        rec_t rec;
        @(negedge clk);
        #2;
        case (rdy_mode)
            0: win_rdy_i = 1'b1;
            1: begin rdy_tog = !rdy_tog; win_rdy_i = rdy_tog; end
            2: win_rdy_i = 1'($urandom_range(0, 1));
            default: win_rdy_i = 1'b0;
        endcase
        in_vld_i = vld; sof_i = s; eol_i = e; eof_i = f;
        col0_i = c0; col1_i = c1; col2_i = c2;
        #1;
        accepted = vld && in_rdy_o;
        if (win_vld_o && win_rdy_i) begin
            rec.win = win_o; rec.sof = win_sof_o; rec.eol = win_eol_o; rec.eof = win_eof_o;
            dut_log.push_back(rec);
        end
    endtask

    task automatic idleCycles(input int n);
        logic a;
        for (int i = 0; i < n; i++) driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, a);
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic f,
                                 input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        logic a;
        for (int t = 0; t < 200; t++) begin
            if (bubble_en && $urandom_range(0, 3) == 0) idleCycles(1);
            driveCycle(1'b1, s, e, f, c0, c1, c2, a);
            if (a) return;
        end
        n_vec++;
        n_mis++;
        $display("[TB] FAIL accept_timeout: pixel not accepted in 200 cycles, expected acceptance");
    endtask

    // Send a w x h frame; cut >= 0 stops after that many pixels with no eof.
    task automatic sendFrame(input int w, input int h, input bit rnd, input int cut);
        int n = 0;
        logic [7:0] c0, c1, c2;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (cut >= 0 && n >= cut) return;
                if (rnd) begin
                    c0 = 8'($urandom); c1 = 8'($urandom); c2 = 8'($urandom);
                end else begin
                    c0 = 8'(y * 16 + x); c1 = 8'((y - 1) * 16 + x); c2 = 8'((y - 2) * 16 + x);
                end
                applyStimulus(x == 0 && y == 0, x == w - 1, (x == w - 1) && (y == h - 1), c0, c1, c2);
                n++;
            end
        end
    endtask

    task automatic checkFrame54(input string tag, input int b);
        win_t w;
        logic [5:0] sv, ev, fv;
        checkOutput({tag, "_count"}, 72'(dut_log.size() - b), 72'(6));
        if (dut_log.size() >= b + 6) begin
            w = dut_log[b].win;
            checkOutput({tag, "_first00"}, 72'(w[0][0]), 72'h00);
            checkOutput({tag, "_first22"}, 72'(w[2][2]), 72'h22);
            w = dut_log[b + 5].win;
            checkOutput({tag, "_last00"}, 72'(w[0][0]), 72'h12);
            checkOutput({tag, "_last11"}, 72'(w[1][1]), 72'h23);
            checkOutput({tag, "_last22"}, 72'(w[2][2]), 72'h34);
            for (int i = 0; i < 6; i++) begin
                sv[i] = dut_log[b + i].sof;
                ev[i] = dut_log[b + i].eol;
                fv[i] = dut_log[b + i].eof;
            end
            checkOutput({tag, "_sofs"}, 72'(sv), 72'(6'b000001));
            checkOutput({tag, "_eols"}, 72'(ev), 72'(6'b100100));
            checkOutput({tag, "_eofs"}, 72'(fv), 72'(6'b100000));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b;
        win_t w;
        #3;
        checkOutput("rst_vld", 72'(win_vld_o), 72'(0));
        checkOutput("rst_win", win_o, 72'(0));
        checkOutput("rst_markers", 72'({win_sof_o, win_eol_o, win_eof_o}), 72'(0));
        checkOutput("rst_err", 72'(err_o), 72'(0));
        checkOutput("rst_rdy", 72'(in_rdy_o), 72'(1));
        @(negedge clk); #2; arst = 1'b0;
        check_en = 1'b1;

        $display("[TB] 5x4 frame, ready high");
        b = dut_log.size();
        rdy_mode = 0;
        sendFrame(5, 4, 1'b0, -1);
        idleCycles(3);
        checkFrame54("f54", b);

        $display("[TB] 5x4 frame, ready toggling");
        b = dut_log.size();
        rdy_mode = 1;
        sendFrame(5, 4, 1'b0, -1);
        idleCycles(4);
        rdy_mode = 0;
        idleCycles(2);
        checkFrame54("f54tog", b);

        $display("[TB] sof in the middle of a frame");
        b = dut_log.size();
        sendFrame(5, 4, 1'b0, 13);
        sendFrame(5, 4, 1'b0, -1);
        idleCycles(3);
        checkOutput("midsof_count", 72'(dut_log.size() - b), 72'(7));
        if (dut_log.size() >= b + 2) begin
            checkOutput("midsof_new_sof", 72'(dut_log[b + 1].sof), 72'(1));
            w = dut_log[b + 1].win;
            checkOutput("midsof_new00", 72'(w[0][0]), 72'h00);
            checkOutput("midsof_new22", 72'(w[2][2]), 72'h22);
        end

        $display("[TB] 2-pixel-wide frame");
        b = dut_log.size();
        sendFrame(2, 5, 1'b0, -1);
        idleCycles(3);
        checkOutput("narrow_count", 72'(dut_log.size() - b), 72'(0));

        $display("[TB] line overflow");
        for (int x = 0; x < 10; x++) begin
            applyStimulus(x == 0, x == 9, x == 9, 8'(x), 8'h0, 8'h0);
            if (x == 7) begin @(posedge clk); #1; checkOutput("err_before", 72'(err_o), 72'(0)); end
            if (x == 8) begin @(posedge clk); #1; checkOutput("err_set", 72'(err_o), 72'(1)); end
        end
        idleCycles(3);
        checkOutput("err_sticky", 72'(err_o), 72'(1));
        sendFrame(3, 3, 1'b0, -1);
        idleCycles(2);
        checkOutput("err_cleared", 72'(err_o), 72'(0));

        $display("[TB] reset while output stalled");
        b = dut_log.size();
        rdy_mode = 3;
        sendFrame(5, 4, 1'b0, 13);
        idleCycles(1);
        checkOutput("hold_vld", 72'(win_vld_o), 72'(1));
        checkOutput("hold_rdy", 72'(in_rdy_o), 72'(0));
        arst = 1'b1;
        #1;
        checkOutput("arst_vld", 72'(win_vld_o), 72'(0));
        @(negedge clk); #2; arst = 1'b0;
        rdy_mode = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h23, 8'h13, 8'h03);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h24, 8'h14, 8'h04);
        for (int x = 0; x < 5; x++) applyStimulus(1'b0, x == 4, x == 4, 8'(48 + x), 8'(32 + x), 8'(16 + x));
        idleCycles(2);
        checkOutput("postrst_discard", 72'(dut_log.size() - b), 72'(0));
        b = dut_log.size();
        sendFrame(5, 4, 1'b0, -1);
        idleCycles(3);
        checkFrame54("postrst", b);

        $display("[TB] randomized frames");
        bubble_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rdy_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) begin
                for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0,
                                                          8'($urandom), 8'($urandom), 8'($urandom));
            end
            sendFrame($urandom_range(1, 10), $urandom_range(1, 5), 1'b1,
                      ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : -1);
        end
        bubble_en = 1'b0;
        rdy_mode = 0;
        idleCycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/conv_win_asm.md
# conv_win_asm

Assembles 3x3 pixel windows for the convolution datapath from three row-aligned pixel columns: the live row and the two delayed rows produced by the line-buffer controllers. It sits directly downstream of the line-buffer stage and upstream of the MAC array. It tracks frame and line position, emits only fully populated windows, and presents them through a single registered valid/ready output stage.

## Interface
Parameters:
- IMAGE_MAX_W, default conv_pkg::IMAGE_MAX_W: maximum accepted line length in pixels.

Ports:
- clk  in  1  clock; all state is on the rising edge.
- arst  in  1  reset; asynchronous, active-high.
- in_vld_i  in  1  input column valid.
- in_rdy_o  out  1  input column accepted when in_vld_i & in_rdy_o.
- col0_i  in  PIXEL_W  pixel (x,y), current row.
- col1_i  in  PIXEL_W  pixel (x,y-1), line buffer 0.
- col2_i  in  PIXEL_W  pixel (x,y-2), line buffer 1.
- sof_i, eol_i, eof_i  in  1 each  first pixel of frame, last pixel of line, last pixel of frame; qualified by accept.
- win_vld_o  out  1  window valid.
- win_rdy_i  in  1  downstream ready.
- win_o  out  9*PIXEL_W  conv_pkg::win_t, [r][c]; r=0 is row y-2, c=0 is column x-2.
- win_sof_o, win_eol_o, win_eof_o  out  1 each  window markers.
- err_o  out  1  sticky line-overflow flag.

## Operation
- Accept: acc = in_vld_i & in_rdy_o. in_rdy_o = ~win_vld_o | win_rdy_i.
- FSM, states IDLE, FILL, RUN; reset state is IDLE.
  - IDLE: discard accepted pixels unless sof_i. A sof_i pixel enters FILL at row 0, column 0.
  - FILL: rows 0 and 1. eol_i increments the row count. When the row count reaches 2, go to RUN.
  - RUN: windows are emitted.
  - An accepted eof_i returns the FSM to IDLE from any state.
  - An accepted sof_i in any state restarts the frame at row 0, column 0 in FILL. This accepted pixel is the new frame's pixel (0,0).
- Column shift registers, three rows by two columns, updated on every acc:
  - sr[r][0] <= sr[r][1]
  - sr[r][1] <= col_r input
  - Row mapping: r=0 takes col2_i, r=1 takes col1_i, r=2 takes col0_i.
- Window formation: the window is sr[r][0], sr[r][1] and the current input, combinationally.
- Column counter xcnt:
  - Width $clog2(IMAGE_MAX_W+1).
  - Cleared on sof_i or eol_i acceptance; otherwise increments on acc.
  - Saturates at IMAGE_MAX_W.
- Row counter ycnt: 2 bits, saturating at 2.
- Emit condition: acc & RUN & (xcnt >= 2). The output is (W-2)x(H-2) windows; there is no padding.
- Output register loads on emit:
  - win_o gets the formed window.
  - win_sof_o = first emit of the frame.
  - win_eol_o = eol_i.
  - win_eof_o = eof_i.
- win_vld_o:
  - Set on emit.
  - Cleared on win_rdy_i when there is no emit in the same cycle.
  - When held with win_rdy_i low, the output register is frozen and in_rdy_o is 0.
- err_o:
  - Set when an acc arrives with xcnt == IMAGE_MAX_W and not eol_i; the pixel is still shifted.
  - Cleared only on an accepted sof_i or reset.

## Timing
- Latency: 1 cycle from an accepted emitting column to win_vld_o.
- Throughput: 1 window per cycle while win_rdy_i stays high.
- Reset values:
  - win_vld_o 0, win_o 0, all marker outputs 0, err_o 0.
  - in_rdy_o 1.
  - FSM IDLE, xcnt 0, ycnt 0.
- Reset mid-frame: all state returns to its reset value. Any in-flight window is dropped.
- Lines shorter than 3 pixels produce no windows, but eol_i still advances the row count.
- Frames shorter than 3 rows produce no windows.
- sof_i and eol_i on the same pixel: treat as a 1-pixel line, so ycnt becomes 1.
- eof_i on a line of at least 3 pixels: the last window carries win_eol_o=1 and win_eof_o=1.

## Structure
- conv_pkg gains win_t (pixel_t [2:0][2:0]) and WIN_K=3. PIXEL_W and IMAGE_MAX_W already live there.
- One sub-module, conv_win_col_sr: a per-row two-deep enable shift register, instantiated 3x.
- Counters, FSM and the output register live in the top level.

## Test plan
- 5x4 frame, col0=y*16+x, row-aligned col1/col2, win_rdy_i=1 -> 6 windows. First window [0][0]=0x00, [2][2]=0x22. win_sof_o on the first window, win_eol_o on windows 3 and 6, win_eof_o on window 6.
- Same frame with win_rdy_i toggled 1/0 every cycle -> identical window sequence. in_rdy_o is low whenever win_vld_o=1 and win_rdy_i=0.
- sof_i asserted at pixel (3,2) of a frame -> no windows emitted from the old frame after that point. The new frame's first window arrives after 2 new rows plus 3 pixels.
- 2-pixel-wide, 5-row frame -> win_vld_o never asserts. The FSM reaches RUN and returns to IDLE on eof_i.
- IMAGE_MAX_W=8, line of 10 pixels -> err_o=1 from the cycle after pixel 9. It stays 1 until the next sof_i.
- arst pulsed while win_vld_o=1 with win_rdy_i=0 -> win_vld_o=0 immediately. Pixels before the next sof_i are discarded.
